// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with byte-wide register file, auto-increment pointer and local host port
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (3-sample majority filter after each synchroniser).
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR    = 7'h4B,
    parameter int         SUB_ADDR_BYTES = 1,
    parameter int         DEPTH          = 256,
    localparam int        AW             = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          reset_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WRITE,
        S_WR_ACK,
        S_READ,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    logic [1:0]    scl_sync_q, scl_sync_d;
    logic [1:0]    sda_sync_q, sda_sync_d;
    logic          scl_f, sda_f;
    logic          scl_prev_q, scl_prev_d;
    logic          sda_prev_q, sda_prev_d;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rw_q, rw_d;
    logic [1:0]    sub_cnt_q, sub_cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic [7:0]    regs_q [DEPTH];
    logic [7:0]    regs_d [DEPTH];

    logic          i2c_we;
    logic [7:0]    rd_byte;
    logic [AW-1:0] ptr_inc;

    assign scl_sync_d = {scl_sync_q[0], scl_i};
    assign sda_sync_d = {sda_sync_q[0], sda_i};

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, scl_hist_d;
    logic [2:0] sda_hist_q, sda_hist_d;

    assign scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
    assign sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
    // Majority of three: a single-sample pulse never wins the vote.
    assign scl_f = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                   (scl_hist_q[1] & scl_hist_q[2]);
    assign sda_f = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                   (sda_hist_q[1] & sda_hist_q[2]);

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    assign scl_prev_d = scl_f;
    assign sda_prev_d = sda_f;
    assign scl_rise   = scl_f & ~scl_prev_q;
    assign scl_fall   = ~scl_f & scl_prev_q;
    assign start_det  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    assign rd_byte = regs_q[ptr_q];
    assign ptr_inc = ptr_q + AW'(1);

    // State register
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q   <= 2'b11;
            sda_sync_q   <= 2'b11;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= 8'h00;
            rw_q         <= 1'b0;
            sub_cnt_q    <= 2'd0;
            ptr_q        <= '0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            host_rdata_q <= 8'h00;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rw_q         <= rw_d;
            sub_cnt_q    <= sub_cnt_d;
            ptr_q        <= ptr_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        sub_cnt_d   = sub_cnt_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        i2c_we      = 1'b0;

        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            if (scl_rise && (state_q == S_ADDR || state_q == S_SUB || state_q == S_WRITE)) begin
                shreg_d   = {shreg_q[6:0], sda_f};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                S_ADDR: begin
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shreg_q[7:1] == TARGET_ADDR) begin
                            rw_d      = shreg_q[0];
                            sub_cnt_d = 2'd0;
                            sda_oe_d  = 1'b1;
                            busy_d    = 1'b1;
                            state_d   = S_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            shreg_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            state_d  = S_READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_SUB;
                        end
                    end
                end
                S_SUB: begin
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        // First byte replaces the pointer; a second byte shifts in as the LSBs.
                        if (sub_cnt_q == 2'd0) ptr_d = AW'(shreg_q);
                        else                   ptr_d = AW'({ptr_q, shreg_q});
                        sub_cnt_d = sub_cnt_q + 2'd1;
                        sda_oe_d  = 1'b1;
                        state_d   = S_SUB_ACK;
                    end
                end
                S_SUB_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = (sub_cnt_q == 2'(SUB_ADDR_BYTES)) ? S_WRITE : S_SUB;
                    end
                end
                S_WRITE: begin
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        i2c_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = shreg_q;
                        ptr_d       = ptr_inc;
                        sda_oe_d    = 1'b1;
                        state_d     = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_WRITE;
                    end
                end
                S_READ: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    // Pointer advances on the controller's ACK so the following fall loads the next byte.
                    if (scl_rise) begin
                        if (!sda_f) ptr_d = ptr_inc;
                        else        state_d = S_WAIT_STOP;
                    end else if (scl_fall) begin
                        shreg_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd0;
                        state_d   = S_READ;
                    end
                end
                S_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        sda_oe     = sda_oe_q;
        busy       = busy_q;
        wr_strobe  = wr_strobe_q;
        wr_addr    = wr_addr_q;
        wr_data    = wr_data_q;
        host_rdata = host_rdata_q;
    end

    // Register file: I2C write is applied after the host write so it wins on collision.
    always_comb begin
        regs_d = regs_q;
        if (host_we) regs_d[host_addr] = host_wdata;
        if (i2c_we)  regs_d[ptr_q]     = shreg_q;
        host_rdata_d = regs_q[host_addr];
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h4B, 7-bit I2C target address matched against received address bits.
REQ-002 SHALL have parameter SUB_ADDR_BYTES, default 1, sub-address length in bytes; legal values 1 or 2; 2 means MSB first.
REQ-003 SHALL have parameter DEPTH, default 256, number of 8-bit registers; power of two, 2..65536; AW = log2(DEPTH).
REQ-004 SHALL have port i_clk, input, 1, system clock (100 MHz nominal), all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port scl_i, input, 1, I2C clock line, asynchronous to i_clk.
REQ-007 SHALL have port sda_i, input, 1, I2C data line, asynchronous to i_clk.
REQ-008 SHALL have port sda_oe, output, 1, 1 = pull SDA low (open-drain), 0 = release.
REQ-009 SHALL have ports host_addr (input, AW), host_we (input, 1), host_wdata (input, 8) and host_rdata (output, 8) forming the local register port.
REQ-010 SHALL have ports wr_strobe (output, 1), wr_addr (output, AW) and wr_data (output, 8), a one-cycle notification of each I2C-written byte.
REQ-011 SHALL have port busy, output, 1, high from an address match until STOP, or until a START to another address.

Function
REQ-012 SHALL pass scl_i and sda_i through 2-flop synchronisers; edges are detected on the synchronised values.
REQ-013 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high; both are recognised in every state.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WRITE, WR_ACK, READ, RD_ACK and WAIT_STOP.
REQ-015 START SHALL enter ADDR from any state, including a repeated start; STOP SHALL enter IDLE from any state and release sda_oe.
REQ-016 SHALL sample data on SCL rise and change sda_oe only on SCL fall, never while SCL is high.
REQ-017 In ADDR, after 8 bits: on an address match SHALL ACK; otherwise SHALL go to WAIT_STOP with no ACK.
REQ-018 ACK SHALL be sda_oe=1 from the SCL fall after bit 8 until the next SCL fall.
REQ-019 After a matched write address, SHALL receive SUB_ADDR_BYTES bytes (ACK each) into the pointer, then enter WRITE.
REQ-020 Each WRITE byte SHALL be ACKed, written to reg[pointer], and trigger one wr_strobe with wr_addr=pointer and wr_data=byte; the pointer then increments.
REQ-021 After a matched read address, SHALL drive reg[pointer] MSB first, with bit 7 driven on the SCL fall ending the address ACK.
REQ-022 In RD_ACK, SHALL sample the controller response on SCL rise: ACK increments the pointer and starts the next byte; NACK goes to WAIT_STOP.
REQ-023 SHALL keep the pointer across a repeated start, supporting write-sub-address-then-read.
REQ-024 Pointer increments SHALL wrap from DEPTH-1 to 0; sub-address bits above AW SHALL be discarded.
REQ-025 host_rdata SHALL equal reg[host_addr] one cycle after host_addr is applied.
REQ-026 host_we SHALL write host_wdata to reg[host_addr] on the next edge; an I2C write to the same address in the same cycle SHALL win.
REQ-027 A START or STOP mid-byte SHALL discard the partial byte: no register write and no wr_strobe.

Reset
REQ-028 reset_n low SHALL force sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0, pointer=0 and state IDLE, asynchronously.
REQ-029 Register contents SHALL reset to 8'h00.
REQ-030 A reset during any transfer SHALL release SDA immediately; the target then ignores the bus until the next START.

Configuration
REQ-031 With I2C_TARGET_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow each synchroniser, adding 2 cycles of latency and rejecting pulses of 1 cycle or less.
REQ-032 Without I2C_TARGET_GLITCH_FILTER_EN, the synchroniser outputs SHALL be used directly.

Verification
REQ-033 Write 0x96, sub 0x2E, data 0xFE, 0x07, STOP -> all bytes ACKed; reg[0x2E]=0xFE, reg[0x2F]=0x07; two wr_strobe pulses.
REQ-034 Write 0x96, sub 0x2E, repeated START, 0x97, read 2 bytes with ACK then NACK -> read data 0xFE, 0x07; sda_oe=0 after the NACK.
REQ-035 Address 0x98 (7'h4C) -> no ACK, busy stays 0, registers unchanged, sda_oe never asserted.
REQ-036 DEPTH=16, sub 0x0F, write 0xAA, 0x55 -> reg[15]=0xAA, reg[0]=0x55.
REQ-037 STOP after 4 data bits, then reset asserted mid-read -> no write or strobe from the partial byte; sda_oe=0 within the reset assertion.
REQ-038 With I2C_TARGET_GLITCH_FILTER_EN, 1-cycle SCL glitches during a write -> data is still correct; without it, the same stimulus corrupts the data.
